// File: rtl/ucode_pkg.sv
// Shared definitions for the micro-sequencer: sequencing codes, trigger opcodes
// and bit positions of the instruction and micro-word fields.
package ucode_pkg;

  typedef enum logic [1:0] {
    SEQ_NEXT  = 2'b00,
    SEQ_LOOP  = 2'b01,
    SEQ_LDCNT = 2'b10,
    SEQ_END   = 2'b11
  } seq_e;

  localparam logic [6:0] OPC_MUL  = 7'b0010000;
  localparam logic [6:0] OPC_MULS = 7'b0011000;

  localparam int INSTR_OPC_LSB = 25;
  localparam int INSTR_OPC_W   = 7;
  localparam int INSTR_RD_LSB  = 21;
  localparam int INSTR_RN_LSB  = 17;
  localparam int INSTR_RM_LSB  = 0;
  localparam int REG_W         = 4;

  localparam int UW_SEQ_LSB = 30;
  localparam int UW_TGT_LSB = 22;
  localparam int UW_TGT_W   = 8;
  localparam int UW_CNT_LSB = 16;
  localparam int UW_CNT_W   = 6;
  localparam int UW_PAY_W   = 16;

  function automatic seq_e uw_seq(input logic [31:0] w);
    return seq_e'(w[UW_SEQ_LSB +: 2]);
  endfunction

endpackage

// File: rtl/ucode_next_addr.sv
// Next micro-ROM address and loop counter value for the word currently on the ROM
// output; holds everything when the uop is not accepted.
module ucode_next_addr
  import ucode_pkg::*;
#(
  parameter int UA_W = 8
) (
  input  logic [1:0]          seq,
  input  logic [UA_W-1:0]     target,
  input  logic [UW_CNT_W-1:0] cnt_imm,
  input  logic [UA_W-1:0]     addr_q,
  input  logic [UW_CNT_W-1:0] loop_cnt,
  input  logic                accept,
  output logic [UA_W-1:0]     next_addr,
  output logic [UW_CNT_W-1:0] loop_cnt_nxt
);

  logic [UA_W-1:0] addr_inc;

  assign addr_inc = addr_q + UA_W'(1);

  always_comb begin
    next_addr    = addr_q;
    loop_cnt_nxt = loop_cnt;
    if (accept) begin
      unique case (seq_e'(seq))
        SEQ_NEXT:  next_addr = addr_inc;
        SEQ_LDCNT: begin
          loop_cnt_nxt = cnt_imm;
          next_addr    = addr_inc;
        end
        SEQ_LOOP: begin
          if (loop_cnt != '0) begin
            loop_cnt_nxt = loop_cnt - UW_CNT_W'(1);
            next_addr    = target;
          end else begin
            next_addr = addr_inc;
          end
        end
        default: next_addr = addr_q;
      endcase
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Micro-sequencer that replaces MUL/MULS in IF/ID with a micro-ROM driven uop stream,
// stalling IF until the END word is handed to ID.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int              UA_W       = 8,
  parameter int              UW_W       = 32,
  parameter logic [UA_W-1:0] MUL_ENTRY  = 8'h00,
  parameter logic [UA_W-1:0] MULS_ENTRY = 8'h20,
  parameter int              MAX_STEPS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ifid_instr,
  input  logic             ifid_valid,
  input  logic             flush,
  output logic [UA_W-1:0]  uc_rom_addr,
  input  logic [UW_W-1:0]  uc_rom_data,
  input  logic             uop_ready,
  output logic             uop_valid,
  output logic [15:0]      uop_payload,
  output logic [REG_W-1:0] uc_rd,
  output logic [REG_W-1:0] uc_rn,
  output logic [REG_W-1:0] uc_rm,
  output logic             hold_if,
  output logic             uc_active,
  output logic             uc_err
);

  localparam int SC_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [UA_W-1:0]      addr_q, addr_d;
  logic [UW_CNT_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [SC_W-1:0]      step_cnt_q, step_cnt_d;
  logic [REG_W-1:0]     rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;

  logic [INSTR_OPC_W-1:0] opc;
  logic                 is_mul, is_muls, trigger, running, accept, runaway, finish;
  seq_e                 seq, seq_eff;
  logic [UA_W-1:0]      entry, na_addr;
  logic [UW_CNT_W-1:0]  na_loop_cnt;
  logic                 unused_instr_bits;

  assign opc     = ifid_instr[INSTR_OPC_LSB +: INSTR_OPC_W];
  assign is_mul  = (opc == OPC_MUL);
  assign is_muls = (opc == OPC_MULS);
  assign entry   = is_muls ? MULS_ENTRY : MUL_ENTRY;
  assign seq     = uw_seq(uc_rom_data[31:0]);
  assign unused_instr_bits = ^ifid_instr[INSTR_RN_LSB-1:INSTR_RM_LSB+REG_W];

  // Flush and reset both suppress the trigger and the handshake in the same cycle.
  assign trigger = (state_q == ST_IDLE) && ifid_valid && (is_mul || is_muls) && !flush && !rst;
  assign running = (state_q == ST_RUN) && !flush && !rst;
  assign accept  = running && uop_ready;
  assign runaway = accept && (seq != SEQ_END) && (step_cnt_q == SC_W'(MAX_STEPS - 1));
  assign finish  = accept && ((seq == SEQ_END) || runaway);
  // A runaway abort behaves exactly like END, so the loop counter is left untouched.
  assign seq_eff = runaway ? SEQ_END : seq;

  ucode_next_addr #(
    .UA_W (UA_W)
  ) u_next_addr (
    .seq          (seq_eff),
    .target       (UA_W'(uc_rom_data[UW_TGT_LSB +: UW_TGT_W])),
    .cnt_imm      (uc_rom_data[UW_CNT_LSB +: UW_CNT_W]),
    .addr_q       (addr_q),
    .loop_cnt     (loop_cnt_q),
    .accept       (accept),
    .next_addr    (na_addr),
    .loop_cnt_nxt (na_loop_cnt)
  );

  always_comb begin
    state_d     = state_q;
    uc_rom_addr = addr_q;
    loop_cnt_d  = loop_cnt_q;
    step_cnt_d  = step_cnt_q;
    rd_d        = rd_q;
    rn_d        = rn_q;
    rm_d        = rm_q;
    if (rst) begin
      uc_rom_addr = '0;
    end else if (flush) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (trigger) begin
        uc_rom_addr = entry;
        step_cnt_d  = '0;
        rd_d        = ifid_instr[INSTR_RD_LSB +: REG_W];
        rn_d        = ifid_instr[INSTR_RN_LSB +: REG_W];
        rm_d        = ifid_instr[INSTR_RM_LSB +: REG_W];
        state_d     = ST_RUN;
      end
    end else begin
      uc_rom_addr = na_addr;
      loop_cnt_d  = na_loop_cnt;
      if (accept) step_cnt_d = step_cnt_q + SC_W'(1);
      if (finish) state_d = ST_IDLE;
    end
    addr_d = uc_rom_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      loop_cnt_q <= '0;
      step_cnt_q <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      loop_cnt_q <= loop_cnt_d;
      step_cnt_q <= step_cnt_d;
      rd_q       <= rd_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
    end
  end

  assign uop_valid   = running;
  assign uc_active   = (state_q == ST_RUN) && !rst;
  assign hold_if     = trigger || (running && !finish);
  assign uc_err      = runaway;
  assign uop_payload = uc_rom_data[UW_PAY_W-1:0];
  assign uc_rd       = rd_q;
  assign uc_rn       = rn_q;
  assign uc_rm       = rm_q;

endmodule
